sprite_rom_arbiter: RTL and testbench
=====================================

Name: sprite_rom_arbiter

Overview:
- Shares one synchronous-read sprite/tile ROM among NUM_REQ pixel-path requesters (player blobs, static grid sprites, HUD digits).
- Sits between the per-object sprite renderers and the single BRAM port that holds sprite bitmaps.
- Round-robin, one grant per cycle, tagged response return.
- Priority pointer is re-seeded at each frame start so arbitration order is identical every frame.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_WIDTH, 12, sprite ROM address width
- DATA_WIDTH, 12, ROM word width (12-bit RGB pixel)
- ROM_LATENCY, 2, cycles from rom_en high to rom_data valid (1..4)

Ports:
- clock  in  1  pixel clock; the only clock
- reset  in  1  asynchronous, active-high reset
- vsync  in  1  XVGA vertical sync, active low
- req  in  NUM_REQ  per-requester read request; held until granted
- addr  in  NUM_REQ x ADDR_WIDTH  per-requester address; stable while req is high
- grant  out  NUM_REQ  one-hot; combinational from req and ptr
- rom_en  out  1  registered ROM read enable
- rom_addr  out  ADDR_WIDTH  registered ROM address
- rom_data  in  DATA_WIDTH  ROM read data
- rdata  out  DATA_WIDTH  response data; equals rom_data
- rvalid  out  NUM_REQ  one-hot response tag
- starve_err  out  NUM_REQ  sticky flag: requester waited too long

Behaviour:
- Reset (async, active-high):
  - ptr=0; rom_en=0; rom_addr=0; tag pipeline cleared; rvalid=0; starve_err=0; wait counters=0.
  - grant is 0 while reset is high.
  - In-flight responses are discarded; no rvalid follows reset.
- Arbitration:
  - Search req from index ptr upward, wrapping modulo NUM_REQ. The first set bit wins.
  - grant is one-hot and is 0 when req is 0.
  - A requester samples its grant in cycle N and deasserts req, or presents a new address, from cycle N+1.
  - After a grant to i, ptr <= (i+1) mod NUM_REQ.
- Issue, for a grant in cycle N:
  - At the end-of-N edge: rom_en<=1, rom_addr<=addr[i], tag stage0<=onehot(i).
  - If no grant: rom_en<=0, tag stage0<=0.
  - Back-to-back grants are allowed, giving a throughput of 1 read per cycle.
- Response:
  - The tag pipeline is ROM_LATENCY deep.
  - rvalid = last tag stage; rdata = rom_data (pass-through).
  - rvalid[i] is high in cycle N+1+ROM_LATENCY (3 cycles after grant at default); all other bits are 0.
- Frame seed:
  - vsync is registered once. A falling edge (1 in the previous sample, 0 in the current) is frame_start, lasting one cycle.
  - On frame_start, ptr<=0, and this overrides the post-grant ptr update in the same cycle.
  - The grant issued in that cycle is still serviced normally.
- Starvation monitor:
  - Per requester, an unsigned 4-bit wait counter increments each cycle req[i]=1 and grant[i]=0.
  - It clears on grant or when req is low.
  - When the counter reaches NUM_REQ (fair round-robin never exceeds NUM_REQ-1), starve_err[i]<=1. The flag is sticky until reset.
  - The counter saturates at 15.
- Boundary conditions:
  - All requesters active: grants rotate 0,1,...,NUM_REQ-1,0,... with no gaps.
  - Single requester holding req continuously: granted every cycle. Legal; each grant is a distinct read.
  - req dropped without a grant: no effect; the wait counter clears.
  - Reset mid-burst: the pipeline flushes, and the first grant after release goes to the lowest active index (ptr=0).

Test Plan:
- Reset then idle: req=0 for 20 cycles -> grant=0, rom_en=0, rvalid=0, starve_err=0 throughout.
- Single read: req=4'b0100, addr[2]=12'h3A5; grant[2] in cycle N; ROM model returns 12'hF00 -> rom_addr=12'h3A5 and rom_en=1 in N+1; rvalid=4'b0100 and rdata=12'hF00 in N+3.
- Full contention: req=4'b1111 held, each requester re-requesting after its grant -> grant sequence 1,2,4,8,1,...; rvalid follows the same sequence 3 cycles later with matching data; starve_err stays 0.
- Frame seed: ptr=3 with req=4'b1111, vsync 1->0 -> the cycle after the registered edge is detected, grant goes to requester 0, not 3 or 1.
- Reset mid-flight: grant requester 1, assert reset 1 cycle later for 2 cycles -> no rvalid ever appears for that read; after release with req=4'b1010, first grant=4'b0010.
- Forced starvation: ROM-side test hook holds requester 3 ungranted (inject a req mask override) for 5 cycles -> starve_err[3]=1 and it remains 1 until reset.

Source files
------------

// File: rtl/sprite_rom_arbiter.sv
// sprite_rom_arbiter: round-robin share of one sprite ROM port with tagged, fixed-latency responses
module sprite_rom_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int ADDR_WIDTH  = 12,
    parameter int DATA_WIDTH  = 12,
    parameter int ROM_LATENCY = 2
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          vsync,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          rom_en,
    output logic [ADDR_WIDTH-1:0]         rom_addr,
    input  logic [DATA_WIDTH-1:0]         rom_data,
    output logic [DATA_WIDTH-1:0]         rdata,
    output logic [NUM_REQ-1:0]            rvalid,
    output logic [NUM_REQ-1:0]            starve_err
);
    localparam int PW = $clog2(NUM_REQ);

    logic [PW-1:0]      ptr, gidx, j;
    logic [PW:0]        s;
    logic               vsync_r, vsync_p, frame_start;
    logic [NUM_REQ-1:0] tag [ROM_LATENCY];
    logic [3:0]         wait_cnt [NUM_REQ];

    assign frame_start = vsync_p & ~vsync_r;
    assign rdata       = rom_data;

    // rotating priority search from ptr; scanning downward lets the closest requester win last
    always_comb begin
        grant = '0;
        gidx  = '0;
        s     = '0;
        j     = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            s = {1'b0, ptr} + (PW+1)'(k);
            j = (s >= (PW+1)'(NUM_REQ)) ? PW'(s - (PW+1)'(NUM_REQ)) : PW'(s);
            if (!reset && req[j]) begin
                grant    = '0;
                grant[j] = 1'b1;
                gidx     = j;
            end
        end
    end

    // sample vsync and keep the previous sample for falling-edge detection
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vsync_r <= 1'b0;
            vsync_p <= 1'b0;
        end else begin
            vsync_r <= vsync;
            vsync_p <= vsync_r;
        end
    end

    // priority pointer: frame start reseeds to 0, otherwise step past the winner
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            ptr <= '0;
        else if (frame_start)
            ptr <= '0;
        else if (|grant)
            ptr <= (gidx == PW'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
    end

    // issue the registered ROM read and walk the response tag down the pipeline
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rom_en   <= 1'b0;
            rom_addr <= '0;
            rvalid   <= '0;
            for (int k = 0; k < ROM_LATENCY; k++)
                tag[k] <= '0;
        end else begin
            rom_en <= |grant;
            if (|grant)
                rom_addr <= addr[int'(gidx)*ADDR_WIDTH +: ADDR_WIDTH];
            tag[0] <= grant;
            for (int k = 1; k < ROM_LATENCY; k++)
                tag[k] <= tag[k-1];
            rvalid <= tag[ROM_LATENCY-1];
        end
    end

    // per-requester wait counters with a sticky starvation flag
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            starve_err <= '0;
            for (int i = 0; i < NUM_REQ; i++)
                wait_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!req[i] || grant[i])
                    wait_cnt[i] <= '0;
                else begin
                    if (wait_cnt[i] != 4'd15)
                        wait_cnt[i] <= wait_cnt[i] + 4'd1;
                    if (wait_cnt[i] == 4'(NUM_REQ - 1))
                        starve_err[i] <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// tb_sprite_rom_arbiter: directed stimulus with a queue-based response scoreboard
module tb_sprite_rom_arbiter;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        vsync = 1'b1;
    logic [3:0]  req = 4'b0;
    logic [11:0] a [4];
    logic [47:0] addr;
    logic [3:0]  grant, rvalid, starve_err;
    logic        rom_en;
    logic [11:0] rom_addr, rom_data, rdata;
    logic [11:0] rom_pipe [2];
    logic [15:0] q [$];
    logic [15:0] mon_e;
    int          checks = 0;
    int          errors = 0;

    assign addr     = {a[3], a[2], a[1], a[0]};
    assign rom_data = rom_pipe[1];

    always #5 clock = ~clock;

    sprite_rom_arbiter dut (
        .clock(clock), .reset(reset), .vsync(vsync), .req(req), .addr(addr),
        .grant(grant), .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
        .rdata(rdata), .rvalid(rvalid), .starve_err(starve_err)
    );

    function automatic logic [11:0] rom_fn(input logic [11:0] x);
        return x ^ 12'hCA5;
    endfunction

    // two-cycle synchronous ROM
    always @(posedge clock) begin
        if (rom_en)
            rom_pipe[0] <= rom_fn(rom_addr);
        rom_pipe[1] <= rom_pipe[0];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // response monitor: every rvalid must match the oldest expected response
    always @(negedge clock) begin
        if (rvalid != 4'b0) begin
            if (q.size() == 0)
                chk("unexpected_rvalid", 32'(rvalid), 32'h0);
            else begin
                mon_e = q.pop_front();
                chk("rvalid_tag", 32'(rvalid), 32'(mon_e[15:12]));
                chk("rdata", 32'(rdata), 32'(mon_e[11:0]));
            end
        end
    end

    // one cycle: check grant, log the expected response, then present a new address
    task automatic cyc(input logic [3:0] eg);
        @(negedge clock);
        chk("grant", 32'(grant), 32'(eg));
        for (int i = 0; i < 4; i++)
            if (eg[i])
                q.push_back({eg, rom_fn(a[i])});
        @(posedge clock);
        #1;
        for (int i = 0; i < 4; i++)
            if (eg[i])
                a[i] = a[i] + 12'h111;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        a[0] = 12'h010;
        a[1] = 12'h120;
        a[2] = 12'h230;
        a[3] = 12'h340;
        repeat (3) @(negedge clock);
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_rom_en", 32'(rom_en), 32'h0);
        chk("rst_rom_addr", 32'(rom_addr), 32'h0);
        chk("rst_rvalid", 32'(rvalid), 32'h0);
        chk("rst_starve", 32'(starve_err), 32'h0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        // idle
        repeat (20) cyc(4'b0000);
        chk("idle_rom_en", 32'(rom_en), 32'h0);
        chk("idle_starve", 32'(starve_err), 32'h0);
        // single read: 12'h3A5 ^ 12'hCA5 = 12'hF00
        a[2] = 12'h3A5;
        req = 4'b0100;
        @(negedge clock);
        chk("single_grant", 32'(grant), 32'h4);
        q.push_back({4'b0100, 12'hF00});
        @(posedge clock);
        #1;
        req = 4'b0000;
        a[2] = 12'h230;
        @(negedge clock);
        chk("single_rom_en", 32'(rom_en), 32'h1);
        chk("single_rom_addr", 32'(rom_addr), 32'h3A5);
        @(posedge clock);
        #1;
        repeat (4) cyc(4'b0000);
        // full contention, ptr starts at 3
        req = 4'b1111;
        for (int k = 0; k < 12; k++)
            cyc(4'(4'b0001 << ((3 + k) % 4)));
        chk("contention_starve", 32'(starve_err), 32'h0);
        // frame seed: frame start lands in the cycle where ptr=2, next grant returns to 0
        cyc(4'b1000);
        cyc(4'b0001);
        vsync = 1'b0;
        cyc(4'b0010);
        cyc(4'b0100);
        cyc(4'b0001);
        cyc(4'b0010);
        vsync = 1'b1;
        req = 4'b0000;
        repeat (5) cyc(4'b0000);
        // the reseed skipped requester 3 for five cycles
        chk("seed_starve", 32'(starve_err), 32'h8);
        // reset mid-flight: the killed read must never respond
        req = 4'b0010;
        @(negedge clock);
        chk("flight_grant", 32'(grant), 32'h2);
        @(posedge clock);
        #1;
        req = 4'b1010;
        a[1] = a[1] + 12'h111;
        reset = 1'b1;
        q.delete();
        @(negedge clock);
        chk("inreset_grant", 32'(grant), 32'h0);
        chk("inreset_rom_en", 32'(rom_en), 32'h0);
        chk("inreset_starve", 32'(starve_err), 32'h0);
        @(posedge clock);
        #1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        cyc(4'b0010);
        cyc(4'b1000);
        req = 4'b0000;
        repeat (5) cyc(4'b0000);
        // forced starvation: a frame start every other cycle pins ptr to 0/1
        req = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            vsync = (k % 2) != 0;
            cyc((k % 2) != 0 ? 4'b0010 : 4'b0001);
        end
        vsync = 1'b1;
        req = 4'b0000;
        repeat (5) cyc(4'b0000);
        chk("starve_set", 32'(starve_err), 32'hC);
        repeat (5) cyc(4'b0000);
        chk("starve_sticky", 32'(starve_err), 32'hC);
        reset = 1'b1;
        @(negedge clock);
        chk("starve_cleared", 32'(starve_err), 32'h0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (3) cyc(4'b0000);
        chk("scoreboard_empty", 32'(q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
